// File: rtl/icini_rand_gen_if.sv
// Bundle of seed/consumer handshake and randomness outputs for icini_rand_gen.
// Seed handshake: the slave presents seed_ready; a seed transfers on the
// rising edge where seed_valid and seed_ready are both 1. seed_data must be
// stable while seed_valid is high. en is a per-cycle request with no ready:
// rand_valid marks the cycles whose output bits are freshly produced.
interface icini_rand_gen_if #(
  parameter int LFSR_W = 16
);
  logic              seed_valid;
  logic [LFSR_W-1:0] seed_data;
  logic              seed_ready;
  logic              en;
  logic              port_rand_ref;
  logic              port_rand_mul_0;
  logic              rand_valid;
  logic              seed_err;
  logic              lockup_err;

  modport master (
    output seed_valid, seed_data, en,
    input  seed_ready, port_rand_ref, port_rand_mul_0, rand_valid,
           seed_err, lockup_err
  );

  modport slave (
    input  seed_valid, seed_data, en,
    output seed_ready, port_rand_ref, port_rand_mul_0, rand_valid,
           seed_err, lockup_err
  );
endinterface

// File: rtl/icini_rand_gen.sv
// Fresh-randomness source for the first-order ICINI masked multiplier.
// Each accepted advance runs two Galois LFSR steps: the first step's output
// bit feeds port_rand_ref, the second feeds port_rand_mul_0, so no bit is
// ever shared or reused. Supports reseeding, warm-up discard and lock-up
// recovery. Internal state is exposed on dbg_* outputs.
module icini_rand_gen #(
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS   = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED   = 16'hACE1,
  parameter int                WARMUP = 32
) (
  input  logic              clk,
  input  logic              reset,
  icini_rand_gen_if.slave   rg,
  output logic [1:0]        dbg_state,
  output logic [LFSR_W-1:0] dbg_lfsr,
  output logic [7:0]        dbg_cnt
);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  localparam logic [7:0] WARMUP_C = 8'(WARMUP);
  // State entered after any (re)seed: skip warm-up entirely when it is zero.
  localparam state_t SEEDED_ST = (WARMUP > 0) ? ST_WARMUP : ST_RUN;

  state_t            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              rnd_ref_q, rnd_ref_d;
  logic              rnd_mul_q, rnd_mul_d;
  logic              valid_q, valid_d;
  logic              seed_err_q, seed_err_d;
  logic              lockup_err_q, lockup_err_d;

  // Single observation point of the LFSR state for all next-state logic.
  logic [LFSR_W-1:0] lfsr_cur;
  assign lfsr_cur = lfsr_q;

  // Two chained Galois steps; bit of step 1 and bit of step 2 kept separate.
  logic              step1_bit, step2_bit;
  logic [LFSR_W-1:0] step1_s, step2_s;
  assign step1_bit = lfsr_cur[0];
  assign step1_s   = (lfsr_cur >> 1) ^ (step1_bit ? TAPS : '0);
  assign step2_bit = step1_s[0];
  assign step2_s   = (step1_s >> 1) ^ (step2_bit ? TAPS : '0);

  logic seed_ready_w;
  logic seed_fire;
  logic seed_zero;
  assign seed_ready_w = (state_q != ST_INIT);
  assign seed_fire    = rg.seed_valid & seed_ready_w;
  assign seed_zero    = (rg.seed_data == '0);

  // Next-state and output-register logic; lock-up beats seed beats advance.
  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    cnt_d        = cnt_q;
    rnd_ref_d    = rnd_ref_q;
    rnd_mul_d    = rnd_mul_q;
    valid_d      = 1'b0;
    seed_err_d   = seed_err_q;
    lockup_err_d = lockup_err_q;

    if (state_q == ST_INIT) begin
      lfsr_d  = SEED;
      cnt_d   = 8'd0;
      state_d = SEEDED_ST;
    end else if (lfsr_cur == '0) begin
      lfsr_d       = SEED;
      cnt_d        = 8'd0;
      state_d      = SEEDED_ST;
      lockup_err_d = 1'b1;
    end else if (seed_fire) begin
      // A zero seed would lock the LFSR, so the default seed replaces it.
      lfsr_d     = seed_zero ? SEED : rg.seed_data;
      seed_err_d = seed_err_q | seed_zero;
      cnt_d      = 8'd0;
      state_d    = SEEDED_ST;
    end else if (state_q == ST_WARMUP) begin
      lfsr_d = step2_s;
      if (cnt_q < WARMUP_C) begin
        cnt_d = cnt_q + 8'd1;
      end
      if ((cnt_q + 8'd1) >= WARMUP_C) begin
        state_d = ST_RUN;
      end
    end else if (rg.en) begin
      lfsr_d    = step2_s;
      rnd_ref_d = step1_bit;
      rnd_mul_d = step2_bit;
      valid_d   = 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_INIT;
      lfsr_q       <= '0;
      cnt_q        <= 8'd0;
      rnd_ref_q    <= 1'b0;
      rnd_mul_q    <= 1'b0;
      valid_q      <= 1'b0;
      seed_err_q   <= 1'b0;
      lockup_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      cnt_q        <= cnt_d;
      rnd_ref_q    <= rnd_ref_d;
      rnd_mul_q    <= rnd_mul_d;
      valid_q      <= valid_d;
      seed_err_q   <= seed_err_d;
      lockup_err_q <= lockup_err_d;
    end
  end

  assign rg.seed_ready      = seed_ready_w;
  assign rg.port_rand_ref   = rnd_ref_q;
  assign rg.port_rand_mul_0 = rnd_mul_q;
  assign rg.rand_valid      = valid_q;
  assign rg.seed_err        = seed_err_q;
  assign rg.lockup_err      = lockup_err_q;

  assign dbg_state = state_q;
  assign dbg_lfsr  = lfsr_q;
  assign dbg_cnt   = cnt_q;

endmodule

// File: doc/icini_rand_gen.md
Name: icini_rand_gen

Overview:
- Fresh-randomness source directly upstream of the first-order ICINI masked multiplier.
- Supplies one new refresh bit (port_rand_ref) and one new multiplication bit (port_rand_mul_0) per accepted cycle. Each bit is taken from a separate Galois LFSR step, so no bit is ever shared between the two outputs or reused.
- Supports run-time reseeding via a valid/ready handshake, a configurable warm-up discard period, and lock-up detection.

Parameters:
- LFSR_W, 16, LFSR state width. Fixed at 16 for the polynomial below.
- TAPS, 16'hB400, Galois feedback mask (x^16+x^14+x^13+x^11+1).
- SEED, 16'hACE1, state loaded after reset and on lock-up recovery. Must be non-zero.
- WARMUP, 32, number of LFSR advances discarded after any (re)seed. Range 0..255.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- seed_valid  in  1  seed offer.
- seed_data  in  LFSR_W  new seed value.
- seed_ready  out  1  seed is accepted when seed_valid & seed_ready.
- en  in  1  consumer requests fresh bits this cycle.
- port_rand_ref  out  1  refresh randomness to the multiplier (registered).
- port_rand_mul_0  out  1  multiplication randomness to the multiplier (registered).
- rand_valid  out  1  high for exactly the cycles where the output bits are freshly produced.
- seed_err  out  1  sticky: a zero seed was offered.
- lockup_err  out  1  sticky: LFSR state reached zero.

Behaviour:
- One advance = two successive Galois steps. Each step: out=s[0]; s=s>>1; if out, s^=TAPS.
  - port_rand_ref takes the bit from step 1.
  - port_rand_mul_0 takes the bit from step 2.
- Reset (reset=0 at an edge):
  - state=INIT, lfsr=0, cnt=0.
  - All outputs 0: port_rand_ref, port_rand_mul_0, rand_valid, seed_ready, seed_err, lockup_err.
- INIT, one cycle:
  - lfsr<=SEED, cnt<=0.
  - Next state is WARMUP if WARMUP>0, else RUN.
  - seed_ready=0.
- WARMUP:
  - Advances every cycle regardless of en; output regs hold, rand_valid=0.
  - cnt increments per advance; when cnt reaches WARMUP, next state is RUN.
  - seed_ready=1.
- RUN, en=1:
  - Advance; output regs take the two bits.
  - rand_valid<=1, so the bits are visible one cycle after the en cycle.
- RUN, en=0:
  - No advance; output regs hold their values; rand_valid<=0.
  - Held bits are stale and must not be used.
- seed_ready is combinational: 1 in WARMUP and RUN, 0 in INIT.
- Seed accept (valid & ready), in any state except INIT:
  - lfsr<=seed_data, cnt<=0.
  - Next state is WARMUP, or RUN if WARMUP=0.
  - rand_valid<=0 that cycle; takes priority over en.
- Zero seed:
  - The accept still completes, but lfsr<=SEED is loaded instead and seed_err<=1 (sticky).
- Lock-up: if lfsr==0 at any edge outside INIT:
  - lfsr<=SEED, cnt<=0, state<=WARMUP (or RUN if WARMUP=0).
  - lockup_err<=1 (sticky); rand_valid<=0.
  - Precedence: lock-up over seed accept over advance.
- Errors clear only on reset. Reset mid-warm-up or mid-run fully restarts from INIT.
- cnt is 8 bits and saturates (never wraps) at WARMUP.
- Consumer contract: the multiplier uses port_rand_ref in cycle t and port_rand_mul_0 in cycle t+1. Holding en=1 guarantees a fresh port_rand_ref at t and a fresh port_rand_mul_0 at t+1.

Test Plan:
- Reset held 3 cycles, then released, WARMUP=32, en=1 → all outputs 0 during reset; seed_ready=0 in cycle 1 after release. rand_valid first rises exactly 34 cycles after release (1 INIT + 32 warm-up + 1 register), then stays 1 while en=1.
- WARMUP=0: seed 16'h0001 accepted at cycle T, en=1 from T+1 → T+2: ref=1, mul=0, rand_valid=1; T+3: ref=0, mul=0. Internal lfsr: 16'h5A00 after T+1, 16'h1680 after T+2.
- RUN, en toggled 1,0,0,1 → rand_valid 1,0,0,1 (one-cycle lag). Bits and lfsr are unchanged across the en=0 cycles.
- Zero seed offered in RUN → seed_err=1 next cycle and stays set. lfsr equals SEED (16'hACE1); state is WARMUP; rand_valid=0 for WARMUP+1 cycles.
- lfsr forced to 0 in RUN → next edge lockup_err=1, lfsr=16'hACE1, rand_valid=0. Same cycle seed_valid=1 → seed ignored; lock-up recovery wins.
- seed_valid=1 during WARMUP at cnt=10 → cnt restarts at 0; a full WARMUP is counted again before rand_valid=1.
